// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide execute unit:
// funct3 encodings, FSM state encoding and operand signedness decode.
package ex_muldiv_pkg;

    localparam logic [2:0] MulOpMul    = 3'd0;
    localparam logic [2:0] MulOpMulh   = 3'd1;
    localparam logic [2:0] MulOpMulhsu = 3'd2;
    localparam logic [2:0] MulOpMulhu  = 3'd3;
    localparam logic [2:0] DivOpDiv    = 3'd4;
    localparam logic [2:0] DivOpDivu   = 3'd5;
    localparam logic [2:0] DivOpRem    = 3'd6;
    localparam logic [2:0] DivOpRemu   = 3'd7;

    // Decoder-side switch for the M extension.
    localparam bit MulDivEnable = 1'b1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMul  = 3'd1,
        StDiv  = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } md_state_e;

    // Returns {rs1_is_signed, rs2_is_signed} for a funct3 code.
    function automatic logic [1:0] op_signedness(input logic [2:0] op);
        logic [1:0] s;
        case (op)
            MulOpMulh:   s = 2'b11;
            MulOpMulhsu: s = 2'b10;
            DivOpDiv:    s = 2'b11;
            DivOpRem:    s = 2'b11;
            MulOpMul, MulOpMulhu, DivOpDivu, DivOpRemu: s = 2'b00;
            default:     s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and shift in a quotient bit.
module muldiv_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // quo_i carries the remaining dividend bits MSB-first; quotient bits fill from the bottom.
    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    assign rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: iterative shift-add multiplier and restoring
// divider on operand magnitudes, with sign fix-up, fast paths and valid/ready handshake.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MUL_STEP  = 4,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      waddr_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            we_o,
    output logic [4:0]      waddr_o,
    output logic [XLEN-1:0] result_o,
    output logic            stall_req_o
);

    localparam int unsigned       MUL_ITERS = XLEN / MUL_STEP;
    localparam int unsigned       CW        = $clog2(XLEN);
    localparam logic [CW-1:0]     MUL_LAST  = CW'(MUL_ITERS - 1);
    localparam logic [CW-1:0]     DIV_LAST  = CW'(XLEN - 1);
    localparam logic [XLEN-1:0]   MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q;
    logic [2:0]        op_q;
    logic [4:0]        waddr_q;
    logic              sign_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   divisor_q;
    logic [XLEN-1:0]   result_q;
    logic              valid_q;

    // Operand decode on the input side (used only on accept).
    logic [1:0]      sgn_in;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            in_sign;

    assign sgn_in = op_signedness(op_i);
    assign a_neg  = sgn_in[1] & rs1_i[XLEN-1];
    assign b_neg  = sgn_in[0] & rs2_i[XLEN-1];
    assign abs_a  = a_neg ? -rs1_i : rs1_i;
    assign abs_b  = b_neg ? -rs2_i : rs2_i;

    // A zero divisor must leave the all-ones quotient unnegated.
    always_comb begin
        in_sign = a_neg ^ b_neg;
        if (op_i == DivOpRem) begin
            in_sign = a_neg;
        end else if ((op_i == DivOpDiv) && (rs2_i == '0)) begin
            in_sign = 1'b0;
        end
    end

    logic            div_zero;
    logic            div_ovf;
    logic            mul_zero;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

    assign div_zero = op_i[2] && (rs2_i == '0);
    assign div_ovf  = ((op_i == DivOpDiv) || (op_i == DivOpRem))
                      && (rs1_i == MOST_NEG) && (rs2_i == '1);
    assign mul_zero = !op_i[2] && ((rs1_i == '0) || (rs2_i == '0));
    assign fast_hit = EARLY_OUT && (div_zero || div_ovf || mul_zero);

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = op_i[1] ? rs1_i : '1;
        end else if (div_ovf) begin
            fast_res = op_i[1] ? '0 : MOST_NEG;
        end
    end

    // Multiplier step; in IDLE it runs on the incoming operands so the
    // accept cycle retires the first MUL_STEP bits.
    logic              idle;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] step_mcand;
    logic [XLEN-1:0]   step_mplier;
    logic [2*XLEN-1:0] pp [MUL_STEP];
    logic [2*XLEN-1:0] mul_acc_d;
    logic [2*XLEN-1:0] mul_mcand_d;
    logic [XLEN-1:0]   mul_mplier_d;
    logic [2:0]        fin_op;
    logic              fin_sign;
    logic [2*XLEN-1:0] mul_signed_d;
    logic [XLEN-1:0]   mul_res_d;

    assign idle        = (state_q == StIdle);
    assign step_acc    = idle ? '0 : acc_q;
    assign step_mcand  = idle ? {{XLEN{1'b0}}, abs_a} : mcand_q;
    assign step_mplier = idle ? abs_b : mplier_q;

    for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
        assign pp[gi] = step_mplier[gi] ? (step_mcand << gi) : '0;
    end

    always_comb begin
        mul_acc_d = step_acc;
        for (int k = 0; k < MUL_STEP; k++) begin
            mul_acc_d = mul_acc_d + pp[k];
        end
    end

    assign mul_mcand_d  = step_mcand << MUL_STEP;
    assign mul_mplier_d = step_mplier >> MUL_STEP;
    assign fin_op       = idle ? op_i : op_q;
    assign fin_sign     = idle ? in_sign : sign_q;
    assign mul_signed_d = fin_sign ? -mul_acc_d : mul_acc_d;
    assign mul_res_d    = (fin_op == MulOpMul) ? mul_signed_d[XLEN-1:0]
                                               : mul_signed_d[2*XLEN-1:XLEN];

    logic [XLEN-1:0] div_rem_d;
    logic [XLEN-1:0] div_quo_d;
    logic [XLEN-1:0] fix_mag;
    logic [XLEN-1:0] fix_res_d;

    muldiv_div_step #(
        .XLEN(XLEN)
    ) u_div_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(divisor_q),
        .rem_o    (div_rem_d),
        .quo_o    (div_quo_d)
    );

    assign fix_mag   = op_q[1] ? rem_q : quo_q;
    assign fix_res_d = sign_q ? -fix_mag : fix_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            waddr_q   <= '0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (valid_i && MulDivEnable) begin
                        op_q      <= op_i;
                        waddr_q   <= waddr_i;
                        sign_q    <= in_sign;
                        divisor_q <= abs_b;
                        if (fast_hit) begin
                            result_q <= fast_res;
                            valid_q  <= 1'b1;
                            state_q  <= StDone;
                        end else if (op_i[2]) begin
                            rem_q   <= '0;
                            quo_q   <= abs_a;
                            cnt_q   <= '0;
                            state_q <= StDiv;
                        end else begin
                            acc_q    <= mul_acc_d;
                            mcand_q  <= mul_mcand_d;
                            mplier_q <= mul_mplier_d;
                            cnt_q    <= CW'(1);
                            if (MUL_ITERS == 1) begin
                                result_q <= mul_res_d;
                                valid_q  <= 1'b1;
                                state_q  <= StDone;
                            end else begin
                                state_q <= StMul;
                            end
                        end
                    end
                end
                StMul: begin
                    acc_q    <= mul_acc_d;
                    mcand_q  <= mul_mcand_d;
                    mplier_q <= mul_mplier_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == MUL_LAST) begin
                        result_q <= mul_res_d;
                        valid_q  <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDiv: begin
                    rem_q <= div_rem_d;
                    quo_q <= div_quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == DIV_LAST) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    result_q <= fix_res_d;
                    valid_q  <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ready_o     = (state_q == StIdle);
    assign valid_o     = valid_q;
    assign we_o        = valid_q;
    assign waddr_o     = waddr_q;
    assign result_o    = result_q;
    assign stall_req_o = (state_q != StIdle) && !((state_q == StDone) && ready_i);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: runs each op on an EARLY_OUT=1 and an
// EARLY_OUT=0 instance side by side and checks values, latency and handshake.
module tb_ex_muldiv;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  waddr_i;
    logic        ready_i;

    logic        ready_o, valid_o, we_o, stall_req_o;
    logic [4:0]  waddr_o;
    logic [31:0] result_o;
    logic        ready_s, valid_s, we_s, stall_s;
    logic [4:0]  waddr_s;
    logic [31:0] result_s;

    int checks;
    int errors;

    ex_muldiv dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .waddr_i(waddr_i),
        .valid_o(valid_o), .ready_i(ready_i), .we_o(we_o), .waddr_o(waddr_o),
        .result_o(result_o), .stall_req_o(stall_req_o)
    );

    ex_muldiv #(.EARLY_OUT(1'b0)) dut_s (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_s),
        .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .waddr_i(waddr_i),
        .valid_o(valid_s), .ready_i(ready_i), .we_o(we_s), .waddr_o(waddr_s),
        .result_o(result_s), .stall_req_o(stall_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        op_i = '0; rs1_i = '0; rs2_i = '0; waddr_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ready_o, valid_o, we_o, stall_req_o, waddr_o, result_o} !== {4'b1000, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_fast: got rdy=%b vld=%b we=%b stall=%b wa=%0d res=%h want 1 0 0 0 0 0",
                     ready_o, valid_o, we_o, stall_req_o, waddr_o, result_o);
        end
        checks++;
        if ({ready_s, valid_s, we_s, stall_s, waddr_s, result_s} !== {4'b1000, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_slow: got rdy=%b vld=%b we=%b stall=%b wa=%0d res=%h want 1 0 0 0 0 0",
                     ready_s, valid_s, we_s, stall_s, waddr_s, result_s);
        end
    endtask

    // Issues one op with ready_i=1 and checks both instances' result and latency.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic [31:0] exp,
                         input int lat_f, input int lat_s, input string name);
        int got_f;
        int got_s;
        logic [31:0] res_f;
        logic [31:0] res_s;
        logic [4:0]  wa_f;
        logic        we_f;
        got_f = 0; got_s = 0; res_f = '0; res_s = '0; wa_f = '0; we_f = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready_o, ready_s} !== 2'b11) begin
            errors++;
            $display("FAIL %s_ready: got %b%b want 11", name, ready_o, ready_s);
        end
        op_i = op; rs1_i = a; rs2_i = b; waddr_i = wa; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        for (int k = 1; k <= 60 && (got_f == 0 || got_s == 0); k++) begin
            @(negedge clk);
            if (got_f == 0 && valid_o) begin
                got_f = k; res_f = result_o; wa_f = waddr_o; we_f = we_o;
            end
            if (got_s == 0 && valid_s) begin
                got_s = k; res_s = result_s;
            end
        end
        $display("op %-10s a=%h b=%h -> fast %h @%0d slow %h @%0d", name, a, b, res_f, got_f, res_s, got_s);
        checks++;
        if (res_f !== exp) begin
            errors++;
            $display("FAIL %s_result: got %h want %h", name, res_f, exp);
        end
        checks++;
        if (got_f != lat_f) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, got_f, lat_f);
        end
        checks++;
        if ({wa_f, we_f} !== {wa, 1'b1}) begin
            errors++;
            $display("FAIL %s_waddr_we: got %0d/%b want %0d/1", name, wa_f, we_f, wa);
        end
        checks++;
        if (res_s !== exp) begin
            errors++;
            $display("FAIL %s_result_slow: got %h want %h", name, res_s, exp);
        end
        checks++;
        if (got_s != lat_s) begin
            errors++;
            $display("FAIL %s_latency_slow: got %0d want %0d", name, got_s, lat_s);
        end
    endtask

    task automatic test_mul();
        do_op(OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 8, 8, "mul");
        do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 8, 8, "mulhu");
        do_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 8, 8, "mulh");
        do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8, 32'hFFFF_FFFF, 8, 8, "mulhsu");
        do_op(OP_MULH,   32'hFFFF_FFFD, 32'd5,         5'd9, 32'hFFFF_FFFF, 8, 8, "mulh_neg");
        do_op(OP_MUL,    32'd0,        32'h1234,       5'd10, 32'd0,        1, 8, "mul_zero");
    endtask

    task automatic test_div();
        do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD, 34, 34, "div");
        do_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF, 34, 34, "rem");
        do_op(OP_DIVU, 32'd100,       32'd7, 5'd13, 32'd14,        34, 34, "divu");
        do_op(OP_REMU, 32'd100,       32'd7, 5'd14, 32'd2,         34, 34, "remu");
    endtask

    task automatic test_div_boundary();
        do_op(OP_DIV,  32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1, 34, "div_by0");
        do_op(OP_REMU, 32'd5,         32'd0,         5'd16, 32'd5,         1, 34, "remu_by0");
        do_op(OP_DIV,  32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFFF, 1, 34, "div_neg_by0");
        do_op(OP_REM,  32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFF9, 1, 34, "rem_neg_by0");
        do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1, 34, "div_ovf");
        do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         1, 34, "rem_ovf");
    endtask

    task automatic test_backpressure();
        int got;
        got = 0;
        ready_i = 1'b0;
        @(negedge clk);
        op_i = OP_MUL; rs1_i = 32'd3; rs2_i = 32'd5; waddr_i = 5'd21; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        for (int k = 1; k <= 40 && got == 0; k++) begin
            @(negedge clk);
            if (valid_o) got = k;
        end
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL bp_latency: got %0d want 8", got);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({valid_o, stall_req_o, ready_o, waddr_o, result_o} !== {3'b110, 5'd21, 32'd15}) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b stall=%b rdy=%b wa=%0d res=%h want 1 1 0 21 0000000f",
                         i, valid_o, stall_req_o, ready_o, waddr_o, result_o);
            end
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (stall_req_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_release: got %b want 0", stall_req_o);
        end
        @(negedge clk);
        checks++;
        if ({ready_o, valid_o, stall_req_o, ready_s} !== 4'b1001) begin
            errors++;
            $display("FAIL bp_idle: got rdy=%b vld=%b stall=%b rdy_s=%b want 1 0 0 1",
                     ready_o, valid_o, stall_req_o, ready_s);
        end
        $display("op backpressure mul 3x5 held 5 cycles");
    endtask

    // Squashes an in-flight DIV at accept+10 with flush_i or rst.
    task automatic test_squash(input bit use_rst, input string name);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        op_i = OP_DIV; rs1_i = 32'd100; rs2_i = 32'd7; waddr_i = 5'd22; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (valid_o || valid_s) seen = 1'b1;
        end
        if (use_rst) rst = 1'b1;
        else flush_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush_i = 1'b0;
        checks++;
        if ({ready_o, valid_o, stall_req_o, ready_s, valid_s, stall_s} !== 6'b100100) begin
            errors++;
            $display("FAIL %s_after: got rdy=%b vld=%b stall=%b / %b %b %b want 1 0 0 / 1 0 0",
                     name, ready_o, valid_o, stall_req_o, ready_s, valid_s, stall_s);
        end
        if (use_rst) begin
            checks++;
            if ({waddr_o, result_o} !== {5'd0, 32'd0}) begin
                errors++;
                $display("FAIL %s_clear: got wa=%0d res=%h want 0 0", name, waddr_o, result_o);
            end
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o || valid_s) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_valid: got valid seen=%b want 0", name, seen);
        end
        $display("op %s div squashed at accept+10", name);
        do_op(OP_MUL, 32'd3, 32'd4, 5'd23, 32'd12, 8, 8, {name, "_mul"});
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        op_i = OP_DIV; rs1_i = 32'd5; rs2_i = 32'd0; waddr_i = 5'd24;
        valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        checks++;
        if ({ready_o, valid_o, stall_req_o, ready_s} !== 4'b1001) begin
            errors++;
            $display("FAIL flush_idle: got rdy=%b vld=%b stall=%b rdy_s=%b want 1 0 0 1",
                     ready_o, valid_o, stall_req_o, ready_s);
        end
        $display("op flush_idle div 5/0 with flush not accepted");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul();
        test_div();
        test_div_boundary();
        test_backpressure();
        test_squash(1'b0, "flush");
        test_squash(1'b1, "rst");
        test_flush_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
